// File: rtl/x1_wb_host.sv
// ============================================================================
// Module   : x1_wb_host
// Purpose  : Wishbone initiator that turns PROGRAM/READ requests into X1
//            command writes and polls the result register for READs.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module x1_wb_host #(
    parameter logic [31:0] ADDR        = 32'h3000_000C,
    parameter int          ACK_TIMEOUT = 16,
    parameter int          POLL_GAP    = 8,     // must be >= 1
    parameter int          MAX_POLLS   = 1024
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_op,
    input  logic [4:0]  req_row,
    input  logic [4:0]  req_col,
    input  logic [7:0]  req_data,
    output logic        wbs_cyc_o,
    output logic        wbs_stb_o,
    output logic        wbs_we_o,
    output logic [3:0]  wbs_sel_o,
    output logic [31:0] wbs_adr_o,
    output logic [31:0] wbs_dat_o,
    input  logic [31:0] wbs_dat_i,
    input  logic        wbs_ack_i,
    output logic        rsp_valid,
    output logic [1:0]  rsp_status,
    output logic        rsp_bit
);

    localparam logic [31:0] C_NOT_READY  = 32'hDEAD_C0DE;
    localparam logic [15:0] C_ACK_LAST   = 16'(ACK_TIMEOUT - 1);
    localparam logic [15:0] C_GAP_LAST   = 16'(POLL_GAP - 1);
    localparam logic [15:0] C_POLL_LIMIT = 16'(MAX_POLLS);
    localparam logic [1:0]  C_ST_OK      = 2'b00;
    localparam logic [1:0]  C_ST_TMO     = 2'b01;
    localparam logic [1:0]  C_ST_LIMIT   = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMD  = 3'd1,
        S_GAP  = 3'd2,
        S_POLL = 3'd3,
        S_RESP = 3'd4
    } state_t;

    state_t      r_state;
    logic        r_op;
    logic [15:0] r_to_cnt;
    logic [15:0] r_gap_cnt;
    logic [15:0] r_poll_cnt;

    logic [31:0] w_cmd;
    logic [15:0] w_to_next;
    logic [15:0] w_gap_next;
    logic [15:0] w_poll_next;

    always_comb begin
        w_cmd = {(req_op ? 2'b11 : 2'b01), req_row, req_col, 12'h000,
                 (req_op ? req_data : 8'h00)};
    end

    // All counters saturate instead of wrapping
    assign w_to_next   = (r_to_cnt   == 16'hFFFF) ? r_to_cnt   : r_to_cnt   + 16'd1;
    assign w_gap_next  = (r_gap_cnt  == 16'hFFFF) ? r_gap_cnt  : r_gap_cnt  + 16'd1;
    assign w_poll_next = (r_poll_cnt == 16'hFFFF) ? r_poll_cnt : r_poll_cnt + 16'd1;

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state    <= S_IDLE;
            r_op       <= 1'b0;
            r_to_cnt   <= 16'd0;
            r_gap_cnt  <= 16'd0;
            r_poll_cnt <= 16'd0;
            req_ready  <= 1'b1;
            wbs_cyc_o  <= 1'b0;
            wbs_stb_o  <= 1'b0;
            wbs_we_o   <= 1'b0;
            wbs_sel_o  <= 4'h0;
            wbs_adr_o  <= 32'h0;
            wbs_dat_o  <= 32'h0;
            rsp_valid  <= 1'b0;
            rsp_status <= 2'b00;
            rsp_bit    <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready  <= 1'b0;
                        r_op       <= req_op;
                        wbs_dat_o  <= w_cmd;
                        wbs_cyc_o  <= 1'b1;
                        wbs_stb_o  <= 1'b1;
                        wbs_we_o   <= 1'b1;
                        wbs_sel_o  <= 4'hF;
                        wbs_adr_o  <= ADDR;
                        r_to_cnt   <= 16'd0;
                        r_gap_cnt  <= 16'd0;
                        r_poll_cnt <= 16'd0;
                        r_state    <= S_CMD;
                    end
                end

                S_CMD, S_POLL: begin
                    if (wbs_ack_i || (r_to_cnt == C_ACK_LAST)) begin
                        wbs_cyc_o <= 1'b0;
                        wbs_stb_o <= 1'b0;
                        wbs_we_o  <= 1'b0;
                        wbs_sel_o <= 4'h0;
                        wbs_adr_o <= 32'h0;
                        r_to_cnt  <= 16'd0;
                        r_gap_cnt <= 16'd0;
                    end else begin
                        r_to_cnt <= w_to_next;
                    end

                    if (wbs_ack_i) begin
                        if (r_state == S_CMD) begin
                            if (r_op) begin
                                rsp_valid  <= 1'b1;
                                rsp_status <= C_ST_OK;
                                rsp_bit    <= 1'b0;
                                r_state    <= S_RESP;
                            end else begin
                                r_state <= S_GAP;
                            end
                        end else if (wbs_dat_i == C_NOT_READY) begin
                            r_poll_cnt <= w_poll_next;
                            if (w_poll_next == C_POLL_LIMIT) begin
                                rsp_valid  <= 1'b1;
                                rsp_status <= C_ST_LIMIT;
                                rsp_bit    <= 1'b0;
                                r_state    <= S_RESP;
                            end else begin
                                r_state <= S_GAP;
                            end
                        end else begin
                            rsp_valid  <= 1'b1;
                            rsp_status <= C_ST_OK;
                            rsp_bit    <= wbs_dat_i[0];
                            r_state    <= S_RESP;
                        end
                    end else if (r_to_cnt == C_ACK_LAST) begin
                        rsp_valid  <= 1'b1;
                        rsp_status <= C_ST_TMO;
                        rsp_bit    <= 1'b0;
                        r_state    <= S_RESP;
                    end
                end

                S_GAP: begin
                    if (r_gap_cnt == C_GAP_LAST) begin
                        wbs_cyc_o <= 1'b1;
                        wbs_stb_o <= 1'b1;
                        wbs_we_o  <= 1'b0;
                        wbs_sel_o <= 4'hF;
                        wbs_adr_o <= ADDR;
                        r_to_cnt  <= 16'd0;
                        r_state   <= S_POLL;
                    end else begin
                        r_gap_cnt <= w_gap_next;
                    end
                end

                S_RESP: begin
                    rsp_status <= 2'b00;
                    rsp_bit    <= 1'b0;
                    req_ready  <= 1'b1;
                    r_state    <= S_IDLE;
                end

                default: begin
                    req_ready <= 1'b1;
                    r_state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire
